handle_multi_draw: RTL
======================

// Module: handle_multi_draw
// PURPOSE
//  Parametrised draw sequencer in GameControl; next generation of the fixed 14-card initial-draw handler.
//  Runs a runtime-selected number of draw_one_place_send_msg transactions for one player.
//  Stops early when the deck is empty. Optionally sends a trailing STATE_TURN message.
//  Muxes the sub-engine ctrl bus onto its own ctrl outputs toward the interboard sender.
// PARAMETERS
//  ACTIVE_STATE  `GAME_P1_INIT_DRAW  cur_game_state value in which a start is accepted
//  MAX_DRAW      14                  max draws per run; CNT_W = $clog2(MAX_DRAW+1)
//  WDOG_CYC      1048576             per-draw timeout in cycles (used only with DRAW_WDOG_EN)
// PORTS
//  clk              in   1      system clock
//  rst_n            in   1      async active-low reset
//  interboard_rst   in   1      sync active-high soft reset, same effect as rst_n
//  draw_en          in   1      start request
//  cur_game_state   in   4      global game state
//  req_num          in   CNT_W  draws requested, sampled at start
//  send_turn        in   1      1 = send STATE_TURN at end, sampled at start
//  deck_empty       in   1      no card left to draw (available_card==0)
//  inter_ready      in   1      interboard sender idle/complete
//  sub_en           out  1      1-cycle start pulse to draw engine
//  sub_done         in   1      draw engine finished one draw+place+msg
//  sub_ctrl_*       in   -      en/move_dir/block_x[5]/block_y[3]/msg_type[4]/card[6]/sel_len[3] from engine
//  ctrl_*           out  -      same fields, muxed toward interboard sender
//  drawn_cnt        out  CNT_W  draws completed in current/last run
//  draw_done        out  1      1-cycle pulse, run finished
//  draw_aborted     out  1      valid with draw_done: run ended short (empty deck / timeout)
// BEHAVIOUR
//  - Reset (either): state IDLE; drawn_cnt, target, flags, all outputs 0. Mid-run reset drops sub_en and
//    ctrl_en next edge; no draw_done is emitted.
//  - start = IDLE & draw_en & cur_game_state==ACTIVE_STATE & req_num!=0. Otherwise draw_en is ignored.
//  - req_num==0 start is ignored. req_num>MAX_DRAW clamps to MAX_DRAW.
//  - At start, latch target and send_turn, clear drawn_cnt.
//  - At start, if deck_empty: go to FIN with aborted=1 and no sub_en. Otherwise assert sub_en the
//    same cycle and go to WAIT_DRAW.
//  - WAIT_DRAW: on sub_done, drawn_cnt+=1 and go to COUNT.
//  - COUNT, 1 cycle, priority order:
//    1) drawn_cnt==target: go to TURN if latched send_turn, else FIN.
//    2) deck_empty: set aborted; go to TURN if send_turn, else FIN.
//    3) otherwise assert sub_en and go to WAIT_DRAW.
//  - TURN: ctrl_en=1 for exactly the entry cycle. ctrl_msg_type=`STATE_TURN, other fields 0, held
//    until exit. Go to FIN when inter_ready=1, sampled from the cycle after entry.
//  - FIN: draw_done=1 and draw_aborted=flag for 1 cycle; go to IDLE. drawn_cnt holds until the next start.
//  - Ctrl mux: in WAIT_DRAW or on any sub_en cycle, ctrl_* = sub_ctrl_*. In TURN, the STATE_TURN
//    fields above. Elsewhere all 0.
//  - Start-to-first-sub_en latency 0 cycles. Inter-draw gap: 1 cycle (COUNT).
//  - sub_done outside WAIT_DRAW is ignored. drawn_cnt never exceeds target; no wrap.
//  - draw_en held high through FIN restarts only after one IDLE cycle.
// CONFIGURATION
//  DRAW_WDOG_EN defined: a counter runs in WAIT_DRAW and is cleared on each entry. Reaching WDOG_CYC-1
//    without sub_done forces FIN with draw_aborted=1. No STATE_TURN is sent. A simultaneous sub_done wins.
//  DRAW_WDOG_EN undefined: no counter; WAIT_DRAW waits indefinitely; WDOG_CYC unused.
// TESTING
//  1 req_num=14, send_turn=1, engine done after 5 cyc -> 14 sub_en pulses, one STATE_TURN ctrl_en,
//    draw_done with drawn_cnt=14, aborted=0.
//  2 req_num=3, send_turn=0 -> 3 draws, no STATE_TURN, draw_done 1 cycle after 3rd COUNT.
//  3 req_num=5, deck_empty rises after 2nd sub_done -> drawn_cnt=2, aborted=1, STATE_TURN sent if enabled.
//  4 cur_game_state!=ACTIVE_STATE, or req_num=0, with draw_en=1 -> no sub_en, stays IDLE.
//  5 rst_n low during 4th draw -> all outputs 0 async; new start later runs from drawn_cnt=0.
//  6 DRAW_WDOG_EN, WDOG_CYC=16, sub_done withheld -> draw_done+aborted 16 cyc after WAIT_DRAW entry.

Source files
------------

// File: rtl/handle_multi_draw.sv
// Draw sequencer: runs up to MAX_DRAW draw-engine transactions for one player, stops early on an
// empty deck, optionally sends a trailing STATE_TURN message. Optional watchdog: DRAW_WDOG_EN.
`ifndef GAME_P1_INIT_DRAW
`define GAME_P1_INIT_DRAW 4'd2
`endif
`ifndef STATE_TURN
`define STATE_TURN 4'd3
`endif

module handle_multi_draw #(
    parameter logic [3:0] ACTIVE_STATE = `GAME_P1_INIT_DRAW,
    parameter int          MAX_DRAW     = 14,
    parameter int          WDOG_CYC     = 1048576,
    localparam int         CNT_W        = $clog2(MAX_DRAW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             interboard_rst,
    input  logic             draw_en,
    input  logic [3:0]       cur_game_state,
    input  logic [CNT_W-1:0] req_num,
    input  logic             send_turn,
    input  logic             deck_empty,
    input  logic             inter_ready,
    output logic             sub_en,
    input  logic             sub_done,
    input  logic             sub_ctrl_en,
    input  logic             sub_ctrl_move_dir,
    input  logic [4:0]       sub_ctrl_block_x,
    input  logic [2:0]       sub_ctrl_block_y,
    input  logic [3:0]       sub_ctrl_msg_type,
    input  logic [5:0]       sub_ctrl_card,
    input  logic [2:0]       sub_ctrl_sel_len,
    output logic             ctrl_en,
    output logic             ctrl_move_dir,
    output logic [4:0]       ctrl_block_x,
    output logic [2:0]       ctrl_block_y,
    output logic [3:0]       ctrl_msg_type,
    output logic [5:0]       ctrl_card,
    output logic [2:0]       ctrl_sel_len,
    output logic [CNT_W-1:0] drawn_cnt,
    output logic             draw_done,
    output logic             draw_aborted,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_DRAW = 3'd1,
        S_COUNT     = 3'd2,
        S_TURN      = 3'd3,
        S_FIN       = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] drawn_cnt_q, drawn_cnt_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             turn_req_q, turn_req_d;
    logic             aborted_q, aborted_d;
    logic             turn_first_q, turn_first_d;

    logic             start;
    logic [CNT_W-1:0] req_clamped;
    logic             wdog_hit;
    logic             turn_drive;
    logic             turn_pulse;

    assign start = (state_q == S_IDLE) && draw_en && (cur_game_state == ACTIVE_STATE)
                   && (req_num != '0) && !interboard_rst;
    assign req_clamped = (int'(req_num) > MAX_DRAW) ? CNT_W'(MAX_DRAW) : req_num;

`ifdef DRAW_WDOG_EN
    localparam int WDOG_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

    logic [WDOG_W-1:0] wdog_q, wdog_d;

    // Counts consecutive WAIT_DRAW cycles; zero on the entry cycle.
    always_comb begin
        wdog_d = '0;
        if (state_q == S_WAIT_DRAW && !sub_done && !interboard_rst) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
    end

    assign wdog_hit = (state_q == S_WAIT_DRAW) && (wdog_q == WDOG_W'(WDOG_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    localparam int unused_wdog_cyc = WDOG_CYC;

    assign wdog_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        drawn_cnt_d  = drawn_cnt_q;
        target_d     = target_q;
        turn_req_d   = turn_req_q;
        aborted_d    = aborted_q;
        sub_en       = 1'b0;
        draw_done    = 1'b0;
        draw_aborted = 1'b0;
        turn_drive   = 1'b0;
        turn_pulse   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    target_d    = req_clamped;
                    turn_req_d  = send_turn;
                    drawn_cnt_d = '0;
                    aborted_d   = deck_empty;
                    if (deck_empty) begin
                        state_d = S_FIN;
                    end else begin
                        sub_en  = 1'b1;
                        state_d = S_WAIT_DRAW;
                    end
                end
            end
            S_WAIT_DRAW: begin
                // A completion in the same cycle as a watchdog expiry still counts.
                if (sub_done) begin
                    drawn_cnt_d = drawn_cnt_q + CNT_W'(1);
                    state_d     = S_COUNT;
                end else if (wdog_hit) begin
                    aborted_d = 1'b1;
                    state_d   = S_FIN;
                end
            end
            S_COUNT: begin
                if (drawn_cnt_q == target_q) begin
                    state_d = turn_req_q ? S_TURN : S_FIN;
                end else if (deck_empty) begin
                    aborted_d = 1'b1;
                    state_d   = turn_req_q ? S_TURN : S_FIN;
                end else begin
                    sub_en  = 1'b1;
                    state_d = S_WAIT_DRAW;
                end
            end
            S_TURN: begin
                turn_drive = 1'b1;
                if (turn_first_q) begin
                    turn_pulse = 1'b1;
                end else if (inter_ready) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                draw_done    = 1'b1;
                draw_aborted = aborted_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        turn_first_d = (state_d == S_TURN) && (state_q != S_TURN);

        // Soft reset behaves like rst_n, one edge later.
        if (interboard_rst) begin
            state_d      = S_IDLE;
            drawn_cnt_d  = '0;
            target_d     = '0;
            turn_req_d   = 1'b0;
            aborted_d    = 1'b0;
            turn_first_d = 1'b0;
        end
    end

    always_comb begin
        ctrl_en       = 1'b0;
        ctrl_move_dir = 1'b0;
        ctrl_block_x  = '0;
        ctrl_block_y  = '0;
        ctrl_msg_type = '0;
        ctrl_card     = '0;
        ctrl_sel_len  = '0;
        if (state_q == S_WAIT_DRAW || sub_en) begin
            ctrl_en       = sub_ctrl_en;
            ctrl_move_dir = sub_ctrl_move_dir;
            ctrl_block_x  = sub_ctrl_block_x;
            ctrl_block_y  = sub_ctrl_block_y;
            ctrl_msg_type = sub_ctrl_msg_type;
            ctrl_card     = sub_ctrl_card;
            ctrl_sel_len  = sub_ctrl_sel_len;
        end else if (turn_drive) begin
            ctrl_en       = turn_pulse;
            ctrl_msg_type = `STATE_TURN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            drawn_cnt_q  <= '0;
            target_q     <= '0;
            turn_req_q   <= 1'b0;
            aborted_q    <= 1'b0;
            turn_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            drawn_cnt_q  <= drawn_cnt_d;
            target_q     <= target_d;
            turn_req_q   <= turn_req_d;
            aborted_q    <= aborted_d;
            turn_first_q <= turn_first_d;
        end
    end

    assign drawn_cnt = drawn_cnt_q;
    assign dbg_state = state_q;

endmodule
